slave_resp: RTL and testbench
=============================

SLAVE_RESP -- requirements
Module: slave_resp

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2, range 0..7: cycles between seeing valid and raising ready.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port valid, input, 1, request valid from the interconnect; held high until the handshake.
REQ-005 SHALL have port addr_in, input, 3, target register index.
REQ-006 SHALL have port value_in, input, 3, write data.
REQ-007 SHALL have port ready, output, 1, registered; slave can accept.
REQ-008 SHALL have port rd_addr, input, 3, read index.
REQ-009 SHALL have port rd_data, output, 3, registered read data.
REQ-010 SHALL have port accept_cnt, output, 8, count of completed handshakes.
REQ-011 SHALL have port err, output, 1, sticky protection-violation flag.

Function
REQ-012 SHALL contain an 8-entry by 3-bit register file, regs[0..7].
REQ-013 SHALL implement FSM states IDLE, WAIT, READY, DONE; ready SHALL be 1 only in READY.
REQ-014 IDLE: valid=0 -> stay. If valid=1 and WAIT_CYC>0 -> WAIT, with a 3-bit counter loaded with WAIT_CYC-1. If valid=1 and WAIT_CYC=0 -> READY.
REQ-015 WAIT: valid=0 (request withdrawn) -> IDLE, nothing written. Counter=0 -> READY. Otherwise the counter decrements and the FSM stays in WAIT.
REQ-016 READY: valid=1 at the clock edge is the handshake (valid&&ready). It SHALL write regs[addr_in]<=value_in, increment accept_cnt, and go to DONE.
REQ-017 READY: valid=0 SHALL go to IDLE with no write.
REQ-018 DONE: ready=0 for exactly one cycle, then unconditionally IDLE. This guards against double acceptance while the interconnect drops valid.
REQ-019 Handshake-to-ready latency: ready rises exactly WAIT_CYC+1 cycles after the first edge sampling valid=1.
REQ-020 ready SHALL fall on the edge following the handshake edge.
REQ-021 addr_in/value_in SHALL be sampled only at the handshake edge. Values during IDLE/WAIT are ignored.
REQ-022 rd_data SHALL equal regs[rd_addr] one cycle after rd_addr is presented.
REQ-023 On a same-edge write and read of one index, rd_data SHALL return the pre-write value; the new value is visible the next cycle.
REQ-024 accept_cnt SHALL saturate at 255 and not wrap.
REQ-025 Back-to-back requests (valid high again in the cycle after DONE) SHALL restart from IDLE with full WAIT_CYC latency.

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE and ready=0, and clear the counter, regs[0..7], rd_data, accept_cnt and err.
REQ-027 Reset asserted in WAIT, READY or DONE SHALL abort the transaction with no write. Reset overrides a coincident handshake.
REQ-028 The first request after rst falls SHALL see the full REQ-019 latency.

Configuration
REQ-029 Macro SLAVE_RESP_PROT_EN: when defined, register 0 SHALL be write-protected.
REQ-030 With the macro, a handshake to addr_in=0 SHALL still complete (DONE, accept_cnt++). regs[0] SHALL remain unchanged and err SHALL set to 1, staying set until reset.
REQ-031 Without the macro, err SHALL be constant 0 and address 0 SHALL be writable like the others.

Verification
REQ-032 Reset then idle: rst=1 for 2 cycles, valid=0 -> ready=0, accept_cnt=0, err=0, and rd_data=0 for rd_addr 0..7.
REQ-033 WAIT_CYC=2, valid=1, addr=5, value=6 held until the handshake -> ready high on the 3rd edge after valid was sampled, for exactly 1 cycle. Then regs[5]=6, accept_cnt=1, and rd_addr=5 gives rd_data=6 one cycle later.
REQ-034 WAIT_CYC=2, valid=1 for 1 cycle then 0 -> FSM returns to IDLE, ready never rises, accept_cnt unchanged.
REQ-035 WAIT_CYC=0, with writes to addr 3 of values 1 then 7 back-to-back -> regs[3]=7, accept_cnt=2. A read of addr 3 on the second write edge returns 1.
REQ-036 With SLAVE_RESP_PROT_EN defined, write addr=0 value=4 -> handshake completes, regs[0]=0, err=1 and remains 1 after a later legal write. Without the macro: regs[0]=4, err=0.
REQ-037 With rst=1 asserted on the cycle ready=1 and valid=1 -> no write, accept_cnt=0, state IDLE.

Source files
------------

// File: rtl/slave_resp.sv
// Register-file slave with a ready handshake delayed by WAIT_CYC cycles.
// Optional feature: define SLAVE_RESP_PROT_EN to write-protect register 0 and flag attempts on err.
module slave_resp #(
  parameter int WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [2:0] addr_in,
  input  logic [2:0] value_in,
  output logic       ready,
  input  logic [2:0] rd_addr,
  output logic [2:0] rd_data,
  output logic [7:0] accept_cnt,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WAIT, READY, DONE} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYC - 1);

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] regs [8];

`ifndef SLAVE_RESP_PROT_EN
  assign err = 1'b0;
`endif

  // ready is set alongside every transition into READY, so it mirrors that state as a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      cnt        <= 3'd0;
      rd_data    <= 3'd0;
      accept_cnt <= 8'd0;
      for (int i = 0; i < 8; i++) regs[i] <= 3'd0;
`ifdef SLAVE_RESP_PROT_EN
      err        <= 1'b0;
`endif
    end else begin
      rd_data <= regs[rd_addr];
      ready   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            if (WAIT_CYC == 0) begin
              state <= READY;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!valid) begin
            state <= IDLE;
          end else if (cnt == 3'd0) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        READY: begin
          if (valid) begin
`ifdef SLAVE_RESP_PROT_EN
            if (addr_in == 3'd0) err <= 1'b1;
            else regs[addr_in] <= value_in;
`else
            regs[addr_in] <= value_in;
`endif
            if (accept_cnt != 8'hFF) accept_cnt <= accept_cnt + 8'd1;
            state <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_resp.sv
// Self-checking bench: two slave_resp instances (WAIT_CYC 0 and 2) checked every cycle
// against a transaction-level model of register contents, handshake count and error flag.
module tb_slave_resp;

  logic       clk;
  logic       rst;
  logic       valid      [2];
  logic [2:0] addr_in    [2];
  logic [2:0] value_in   [2];
  logic       ready      [2];
  logic [2:0] rd_addr    [2];
  logic [2:0] rd_data    [2];
  logic [7:0] accept_cnt [2];
  logic       err        [2];

`ifdef SLAVE_RESP_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic [2:0] mem_m   [2][8];
  int         cnt_m   [2];
  logic       err_m   [2];
  logic       exp_rdy [2];
  logic [2:0] exp_rd  [2];
  bit         rd_rand;
  int         n_assert;
  int         n_fail;

  slave_resp #(.WAIT_CYC(0)) dut_a (
    .clk(clk), .rst(rst), .valid(valid[0]), .addr_in(addr_in[0]), .value_in(value_in[0]),
    .ready(ready[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .accept_cnt(accept_cnt[0]), .err(err[0]));

  slave_resp #(.WAIT_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .valid(valid[1]), .addr_in(addr_in[1]), .value_in(value_in[1]),
    .ready(ready[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .accept_cnt(accept_cnt[1]), .err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int wcyc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic modelClear();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) mem_m[d][a] = 3'd0;
      cnt_m[d] = 0;
      err_m[d] = 1'b0;
    end
  endtask

  task automatic modelWrite(input int d, input logic [2:0] a, input logic [2:0] v);
    if (cnt_m[d] < 255) cnt_m[d]++;
    if (PROT && a == 3'd0) err_m[d] = 1'b1;
    else mem_m[d][a] = v;
  endtask

  task automatic check1(input string tag, input int d, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, expv);
    end
  endtask

  // One clock: read data expectation is taken from the model before any write at this edge.
  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) begin
      if (rd_rand) rd_addr[d] = 3'($urandom_range(0, 7));
      exp_rd[d] = rst ? 3'd0 : mem_m[d][rd_addr[d]];
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) modelClear();
  endtask

  task automatic checkOutput(input string tag);
    for (int d = 0; d < 2; d++) begin
      check1({tag, ".ready"}, d, {7'd0, ready[d]}, {7'd0, exp_rdy[d]});
      check1({tag, ".rd_data"}, d, {5'd0, rd_data[d]}, {5'd0, exp_rd[d]});
      check1({tag, ".accept_cnt"}, d, accept_cnt[d], 8'(cnt_m[d]));
      check1({tag, ".err"}, d, {7'd0, err[d]}, {7'd0, err_m[d]});
    end
  endtask

  // Full write transaction; addr/value carry junk until the handshake edge.
  task automatic doWrite(input int d, input logic [2:0] a, input logic [2:0] v);
    valid[d] = 1'b1;
    for (int k = 1; k <= wcyc(d) + 1; k++) begin
      addr_in[d]  = 3'($urandom_range(0, 7));
      value_in[d] = 3'($urandom_range(0, 7));
      exp_rdy[d]  = (k == wcyc(d) + 1);
      applyStimulus();
      checkOutput("wr_wait");
    end
    addr_in[d]  = a;
    value_in[d] = v;
    exp_rdy[d]  = 1'b0;
    applyStimulus();
    modelWrite(d, a, v);
    checkOutput("wr_handshake");
    valid[d]   = 1'($urandom_range(0, 1));
    addr_in[d] = 3'($urandom_range(0, 7));
    applyStimulus();
    checkOutput("wr_done");
    valid[d] = 1'b0;
  endtask

  task automatic withdrawReq(input int d, input int n);
    valid[d] = 1'b1;
    for (int k = 1; k <= n; k++) begin
      addr_in[d]  = 3'($urandom_range(0, 7));
      value_in[d] = 3'($urandom_range(0, 7));
      exp_rdy[d]  = (k == wcyc(d) + 1);
      applyStimulus();
      checkOutput("wd_hold");
    end
    valid[d]   = 1'b0;
    exp_rdy[d] = 1'b0;
    applyStimulus();
    checkOutput("wd_drop");
    applyStimulus();
    checkOutput("wd_idle");
  endtask

  task automatic readSweep(input string tag);
    rd_rand = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr[0] = 3'(a);
      rd_addr[1] = 3'(a);
      applyStimulus();
      checkOutput(tag);
    end
    rd_rand = 1'b1;
  endtask

  // Reset lands on the edge where ready=1 and valid=1, so the handshake must be lost.
  task automatic resetHandshake(input int d);
    valid[d] = 1'b1;
    for (int k = 1; k <= wcyc(d) + 1; k++) begin
      exp_rdy[d] = (k == wcyc(d) + 1);
      applyStimulus();
      checkOutput("rh_wait");
    end
    addr_in[d]  = 3'd6;
    value_in[d] = 3'd5;
    rst         = 1'b1;
    exp_rdy[d]  = 1'b0;
    applyStimulus();
    checkOutput("rh_reset");
    rst      = 1'b0;
    valid[d] = 1'b0;
    applyStimulus();
    checkOutput("rh_after");
    readSweep("rh_sweep");
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rd_rand  = 1'b1;
    rst      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; addr_in[d] = 3'd0; value_in[d] = 3'd0;
      rd_addr[d] = 3'd0; exp_rdy[d] = 1'b0;
    end
    modelClear();

    applyStimulus();
    checkOutput("reset1");
    applyStimulus();
    checkOutput("reset2");
    rst = 1'b0;
    readSweep("reset_sweep");

    doWrite(1, 3'd5, 3'd6);
    rd_rand = 1'b0;
    rd_addr[1] = 3'd5;
    applyStimulus();
    checkOutput("rd5");
    rd_rand = 1'b1;

    withdrawReq(1, 1);

    rd_rand = 1'b0;
    rd_addr[0] = 3'd3;
    doWrite(0, 3'd3, 3'd1);
    doWrite(0, 3'd3, 3'd7);
    applyStimulus();
    checkOutput("rd3");
    rd_rand = 1'b1;

    doWrite(0, 3'd0, 3'd4);
    doWrite(1, 3'd0, 3'd4);
    doWrite(0, 3'd2, 3'd3);
    doWrite(1, 3'd2, 3'd3);
    readSweep("prot_sweep");

    for (int i = 0; i < 60; i++) begin
      int d;
      int op;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      if (op <= 1) doWrite(d, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else if (op == 2) withdrawReq(d, int'($urandom_range(1, wcyc(d) + 1)));
      else begin
        applyStimulus();
        checkOutput("rand_idle");
      end
    end
    readSweep("rand_sweep");

    resetHandshake(1);
    doWrite(1, 3'd4, 3'd2);
    doWrite(0, 3'd1, 3'd5);
    resetHandshake(0);

    valid[1] = 1'b1;
    applyStimulus();
    checkOutput("rw_enter");
    rst = 1'b1;
    applyStimulus();
    checkOutput("rw_reset");
    rst = 1'b0;
    doWrite(1, 3'd7, 3'd3);

    for (int i = 0; i < 258; i++)
      doWrite(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    readSweep("sat_sweep");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
